// File: rtl/dac_output_stage.sv
// Output conditioning stage ahead of the DAC: amplitude scaling, soft start/stop
// envelope, DC offset and saturation to the signed DAC range. Fixed 3-cycle latency.
module dac_output_stage #(
  parameter int unsigned AXIS_TDATA_WIDTH = 16,
  parameter int unsigned DAC_WIDTH        = 14,
  parameter int unsigned CFG_DATA_WIDTH   = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic [CFG_DATA_WIDTH-1:0]   cfg_data,
  input  logic                        start,
  input  logic                        stop,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic [1:0]                  ramp_state,
  output logic                        ramp_done
);

  localparam int unsigned P1W  = AXIS_TDATA_WIDTH + 17;  // sample x {0,amplitude}
  localparam int unsigned P2W  = DAC_WIDTH + 17;         // a x {0,env}
  localparam int unsigned SumW = 18;

  localparam logic [15:0] EnvUnity = 16'd32768;
  localparam logic signed [SumW-1:0] SatMax = SumW'((1 << (DAC_WIDTH - 1)) - 1);
  localparam logic signed [SumW-1:0] SatMin = SumW'(-(1 << (DAC_WIDTH - 1)));

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRampUp   = 2'd1,
    StHold     = 2'd2,
    StRampDown = 2'd3
  } state_e;

  state_e      state_q;
  logic [15:0] env_q;
  logic        done_q;

  logic [15:0] amp_q, off_q, step_q;
  logic [15:0] amp_in;

  logic [16:0] env_sum;
  logic [15:0] env_up, env_dn;

  logic signed [P1W-1:0]       prod1;
  logic signed [P2W-1:0]       prod2;
  logic signed [SumW-1:0]      sum;
  logic        [DAC_WIDTH-1:0] a_d, e_d, y_d;
  logic        [DAC_WIDTH-1:0] a_q, e_q, y_q;
  logic        [15:0]          env_s1_q;
  logic        [2:0]           v_q;

  logic unused_bits;
  assign unused_bits = ^{cfg_data[CFG_DATA_WIDTH-1:48], prod1[P1W-1:17+DAC_WIDTH], prod1[16:0],
                         prod2[P2W-1:15+DAC_WIDTH], prod2[14:0]};

  // Amplitude above unity is clamped when latched so the datapath never sees it.
  always_comb begin
    amp_in = (cfg_data[15:0] > EnvUnity) ? EnvUnity : cfg_data[15:0];
  end

  // Next envelope values for each ramp direction; a zero step jumps straight to the limit.
  always_comb begin
    env_sum = {1'b0, env_q} + {1'b0, step_q};
    if (step_q == 16'd0 || env_sum >= {1'b0, EnvUnity}) begin
      env_up = EnvUnity;
    end else begin
      env_up = env_sum[15:0];
    end
    if (step_q == 16'd0 || env_q <= step_q) begin
      env_dn = 16'd0;
    end else begin
      env_dn = env_q - step_q;
    end
  end

  // Configuration tracks cfg_data only while idle; frozen for the whole waveform otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      amp_q  <= '0;
      off_q  <= '0;
      step_q <= '0;
    end else if (state_q == StIdle) begin
      amp_q  <= amp_in;
      off_q  <= cfg_data[31:16];
      step_q <= cfg_data[47:32];
    end
  end

  // Envelope FSM; stop outranks start, and the envelope moves only on valid samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      env_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          env_q <= '0;
          if (start && !stop) begin
            state_q <= StRampUp;
          end
        end
        StRampUp: begin
          if (stop) begin
            state_q <= StRampDown;
          end else if (s_axis_tvalid) begin
            env_q <= env_up;
            if (env_up == EnvUnity) begin
              state_q <= StHold;
              done_q  <= 1'b1;
            end
          end
        end
        StHold: begin
          env_q <= EnvUnity;
          if (stop) begin
            state_q <= StRampDown;
          end
        end
        StRampDown: begin
          if (start && !stop) begin
            state_q <= StRampUp;
          end else if (s_axis_tvalid) begin
            env_q <= env_dn;
            if (env_dn == 16'd0) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Datapath arithmetic: floor shifts, results already within DAC range before the offset.
  always_comb begin
    prod1 = P1W'($signed(s_axis_tdata)) * P1W'($signed({1'b0, amp_q}));
    a_d   = prod1[17 +: DAC_WIDTH];
    prod2 = P2W'($signed(a_q)) * P2W'($signed({1'b0, env_s1_q}));
    e_d   = prod2[15 +: DAC_WIDTH];
    sum   = {{(SumW - DAC_WIDTH){e_q[DAC_WIDTH-1]}}, e_q} + {{(SumW - 16){off_q[15]}}, off_q};
    if (sum > SatMax) begin
      y_d = SatMax[DAC_WIDTH-1:0];
    end else if (sum < SatMin) begin
      y_d = SatMin[DAC_WIDTH-1:0];
    end else begin
      y_d = sum[DAC_WIDTH-1:0];
    end
  end

  // Three-stage pipeline, advancing every cycle; env is captured alongside stage 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      env_s1_q <= '0;
      e_q      <= '0;
      y_q      <= '0;
      v_q      <= '0;
    end else begin
      a_q      <= a_d;
      env_s1_q <= env_q;
      e_q      <= e_d;
      y_q      <= y_d;
      v_q      <= {v_q[1:0], s_axis_tvalid};
    end
  end

  assign m_axis_tdata  = {{(AXIS_TDATA_WIDTH - DAC_WIDTH){y_q[DAC_WIDTH-1]}}, y_q};
  assign m_axis_tvalid = v_q[2];
  assign ramp_state    = state_q;
  assign ramp_done     = done_q;

endmodule
